// File: rtl/mem_bus_arbiter.sv
// Two-port (instruction/data) arbiter onto a single memory bus, one transaction in flight.
// Optional build macro ARB_ROUND_ROBIN_EN: ties alternate; otherwise the data port wins ties.
module mem_bus_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 128
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_c0_req_valid,
   output logic              o_c0_req_ready,
   input  logic              i_c0_req_we,
   input  logic [ADDR_W-1:0] i_c0_req_addr,
   input  logic [DATA_W-1:0] i_c0_req_data,
   output logic              o_c0_resp_ack,
   output logic [DATA_W-1:0] o_c0_resp_data,
   input  logic              i_c1_req_valid,
   output logic              o_c1_req_ready,
   input  logic              i_c1_req_we,
   input  logic [ADDR_W-1:0] i_c1_req_addr,
   input  logic [DATA_W-1:0] i_c1_req_data,
   output logic              o_c1_resp_ack,
   output logic [DATA_W-1:0] o_c1_resp_data,
   output logic              o_m_req_valid,
   output logic              o_m_req_we,
   output logic [ADDR_W-1:0] o_m_req_addr,
   output logic [DATA_W-1:0] o_m_req_data,
   input  logic              i_m_req_ready,
   input  logic              i_m_resp_ack,
   input  logic [DATA_W-1:0] i_m_resp_data,
   output logic              o_busy
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic              r_winner;
   logic              w_any;
   logic              w_win;
   logic              w_grant;

   assign w_any   = i_c0_req_valid | i_c1_req_valid;
   assign w_grant = (r_state == S_IDLE) && w_any;

`ifdef ARB_ROUND_ROBIN_EN
   // Last-granted port; resets to 1 so the first tie goes to port 0.
   logic r_last;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)        r_last <= 1'b1;
      else if (w_grant) r_last <= w_win;
   end

   assign w_win = (i_c0_req_valid && i_c1_req_valid) ? ~r_last : i_c1_req_valid;
`else
   assign w_win = i_c1_req_valid;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_data   <= '0;
         r_winner <= 1'b0;
      end else if (w_grant) begin
         r_we     <= w_win ? i_c1_req_we   : i_c0_req_we;
         r_addr   <= w_win ? i_c1_req_addr : i_c0_req_addr;
         r_data   <= w_win ? i_c1_req_data : i_c0_req_data;
         r_winner <= w_win;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_any)         w_next = S_REQ;
         S_REQ:   if (i_m_req_ready) w_next = S_RESP;
         S_RESP:  if (i_m_resp_ack)  w_next = S_IDLE;
         default:                    w_next = S_IDLE;
      endcase
   end

   // Ready is gated by reset so every output is low while reset is held.
   always_comb begin
      o_c0_req_ready = 1'b0;
      o_c1_req_ready = 1'b0;
      o_c0_resp_ack  = 1'b0;
      o_c1_resp_ack  = 1'b0;
      o_c0_resp_data = '0;
      o_c1_resp_data = '0;
      o_m_req_valid  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_any && !i_rst) begin
               o_c0_req_ready = ~w_win;
               o_c1_req_ready = w_win;
            end
         end
         S_REQ:  o_m_req_valid = 1'b1;
         S_RESP: begin
            if (i_m_resp_ack) begin
               if (r_winner) begin
                  o_c1_resp_ack  = 1'b1;
                  o_c1_resp_data = i_m_resp_data;
               end else begin
                  o_c0_resp_ack  = 1'b1;
                  o_c0_resp_data = i_m_resp_data;
               end
            end
         end
         default: ;
      endcase
   end

   assign o_m_req_we   = r_we;
   assign o_m_req_addr = r_addr;
   assign o_m_req_data = r_data;
   assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: transaction-level model plus directed literal checks.
module tb_mem_bus_arbiter;
   localparam int AW = 32;
   localparam int DW = 128;

   logic          clk = 1'b0;
   logic          rst;
   logic          c0v, c0we, c1v, c1we;
   logic [AW-1:0] c0a, c1a;
   logic [DW-1:0] c0d, c1d;
   logic          c0rdy, c1rdy, c0ack, c1ack;
   logic [DW-1:0] c0rd, c1rd;
   logic          mv, mwe, mrdy, mack, busy;
   logic [AW-1:0] maddr;
   logic [DW-1:0] mdata, mrd;

   int n_vec = 0;
   int n_err = 0;

   // Model: at most one transaction held, with a flag once memory has accepted it.
   logic          m_have, m_acc, m_owner, m_last, m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_c0_req_valid(c0v), .o_c0_req_ready(c0rdy), .i_c0_req_we(c0we),
      .i_c0_req_addr(c0a), .i_c0_req_data(c0d), .o_c0_resp_ack(c0ack), .o_c0_resp_data(c0rd),
      .i_c1_req_valid(c1v), .o_c1_req_ready(c1rdy), .i_c1_req_we(c1we),
      .i_c1_req_addr(c1a), .i_c1_req_data(c1d), .o_c1_resp_ack(c1ack), .o_c1_resp_data(c1rd),
      .o_m_req_valid(mv), .o_m_req_we(mwe), .o_m_req_addr(maddr), .o_m_req_data(mdata),
      .i_m_req_ready(mrdy), .i_m_resp_ack(mack), .i_m_resp_data(mrd), .o_busy(busy)
   );

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic logic pick();
`ifdef ARB_ROUND_ROBIN_EN
      if (c0v && c1v) return ~m_last;
`else
      if (c0v && c1v) return 1'b1;
`endif
      return c1v;
   endfunction

   task automatic model_reset();
      m_have = 0; m_acc = 0; m_owner = 0; m_last = 1; m_we = 0; m_addr = '0; m_data = '0;
   endtask

   task automatic quiet();
      c0v = 0; c1v = 0; c0we = 0; c1we = 0; c0a = '0; c1a = '0; c0d = '0; c1d = '0;
      mrdy = 0; mack = 0; mrd = '0;
   endtask

   // Called just after a falling edge with inputs set; checks, advances model, returns at next falling edge.
   task automatic step();
      logic w, er0, er1, ea0, ea1, emv;
      #1;
      w = 0; er0 = 0; er1 = 0;
      if (!m_have && (c0v || c1v)) begin
         w = pick();
         er0 = ~w;
         er1 = w;
      end
      emv = m_have && !m_acc;
      ea0 = m_have && m_acc && mack && (m_owner == 1'b0);
      ea1 = m_have && m_acc && mack && (m_owner == 1'b1);
      chk("c0_req_ready", DW'(c0rdy), DW'(er0));
      chk("c1_req_ready", DW'(c1rdy), DW'(er1));
      chk("m_req_valid", DW'(mv), DW'(emv));
      chk("busy", DW'(busy), DW'(m_have));
      chk("c0_resp_ack", DW'(c0ack), DW'(ea0));
      chk("c1_resp_ack", DW'(c1ack), DW'(ea1));
      chk("c0_resp_data", c0rd, ea0 ? mrd : '0);
      chk("c1_resp_data", c1rd, ea1 ? mrd : '0);
      if (emv) begin
         chk("m_req_we", DW'(mwe), DW'(m_we));
         chk("m_req_addr", DW'(maddr), DW'(m_addr));
         chk("m_req_data", mdata, m_data);
      end
      if (!m_have && (c0v || c1v)) begin
         m_have = 1; m_acc = 0; m_owner = w; m_last = w;
         m_we = w ? c1we : c0we; m_addr = w ? c1a : c0a; m_data = w ? c1d : c0d;
      end else if (m_have && !m_acc && mrdy) m_acc = 1;
      else if (m_have && m_acc && mack) m_have = 0;
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [DW-1:0] rnd_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic do_reset();
      rst = 1;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 0;
   endtask

   initial begin
      logic [DW-1:0] a5;
      logic          g[8];
      int            gn;
      a5 = {4{32'hA5A5_A5A5}};
      quiet();
      do_reset();

      // Reset state
      #1;
      chk("rst_busy", DW'(busy), '0);
      chk("rst_m_req_valid", DW'(mv), '0);
      chk("rst_m_req_addr", DW'(maddr), '0);
      @(negedge clk);

      // Single read from c0
      c0v = 1; c0a = 32'h1000;
      #1 chk("rd_grant_c0", DW'(c0rdy), DW'(1'b1));
      step();
      c0v = 0; c0a = '0; mrdy = 1;
      #1 chk("rd_bus_valid", DW'(mv), DW'(1'b1));
      chk("rd_bus_addr", DW'(maddr), DW'(32'h1000));
      chk("rd_bus_we", DW'(mwe), '0);
      step();
      mrdy = 0;
      #1 chk("rd_wait_ack", DW'(c0ack), '0);
      step();
      mack = 1; mrd = a5;
      #1 chk("rd_ack_c0", DW'(c0ack), DW'(1'b1));
      chk("rd_ack_data", c0rd, a5);
      chk("rd_ack_c1", DW'(c1ack), '0);
      step();
      mack = 0;
      #1 chk("rd_idle", DW'(busy), '0);
      step();

      // Backpressure on a c1 write with c0 waiting, spurious acks while in REQ
      c0v = 1; c0a = 32'h1111; c1v = 1; c1we = 1; c1a = 32'h3000; c1d = rnd_line();
      step();
      c1v = 0; mrdy = 0; mack = 1;
      for (int i = 0; i < 5; i++) begin
         #1 chk("bp_no_ready_c0", DW'(c0rdy), '0);
         chk("bp_addr", DW'(maddr), DW'(32'h3000));
         chk("bp_we", DW'(mwe), DW'(1'b1));
         chk("bp_busy", DW'(busy), DW'(1'b1));
         chk("bp_spurious_ack", DW'(c1ack), '0);
         step();
      end
      c0v = 0; mrdy = 1; mack = 0;
      step();
      mrdy = 0; mack = 1;
      #1 chk("bp_wr_ack", DW'(c1ack), DW'(1'b1));
      step();
      // Spurious ack in IDLE
      repeat (2) begin
         #1 chk("idle_spurious_ack", DW'({c0ack, c1ack, busy}), '0);
         step();
      end
      mack = 0;

      // Tie behaviour from a fresh pointer
      quiet();
      do_reset();
      c0v = 1; c1v = 1; c0a = 32'hC0; c1a = 32'hC1; mrdy = 1; mack = 1;
      gn = 0;
      for (int i = 0; i < 12; i++) begin
         #1;
         if ((c0rdy || c1rdy) && gn < 8) begin
            g[gn] = c1rdy;
            gn++;
         end
         step();
      end
      chk("tie_grant_count", DW'(gn), DW'(4));
`ifdef ARB_ROUND_ROBIN_EN
      chk("tie_g0", DW'(g[0]), DW'(1'b0));
      chk("tie_g1", DW'(g[1]), DW'(1'b1));
      chk("tie_g2", DW'(g[2]), DW'(1'b0));
      chk("tie_g3", DW'(g[3]), DW'(1'b1));
`else
      for (int i = 0; i < 4; i++) chk("tie_g_fixed", DW'(g[i]), DW'(1'b1));
`endif

      // Asynchronous reset while in RESP
      quiet();
      step();
      c0v = 1; c0a = 32'h4000;
      step();
      c0v = 0; mrdy = 1;
      step();
      mrdy = 0;
      step();
      c0v = 1; c1v = 1; mack = 1; mrd = a5;
      #2 rst = 1;
      #1 chk("arst_outputs", DW'({c0rdy, c1rdy, c0ack, c1ack, mv, busy}), '0);
      chk("arst_resp_data", c0rd | c1rd, '0);
      chk("arst_addr", DW'(maddr), '0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 0;
      quiet();
      mack = 1;
      repeat (2) step();
      mack = 0;
      c1v = 1; c1we = 1; c1a = 32'h2000; c1d = rnd_line();
      step();
      c1v = 0; mrdy = 1;
      #1 chk("post_rst_addr", DW'(maddr), DW'(32'h2000));
      step();
      mrdy = 0; mack = 1;
      #1 chk("post_rst_wr_ack", DW'(c1ack), DW'(1'b1));
      chk("post_rst_no_c0_ack", DW'(c0ack), '0);
      step();
      mack = 0;

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         c0v = ($urandom_range(0, 1) == 1); c0we = $urandom_range(0, 1) == 1;
         c1v = ($urandom_range(0, 1) == 1); c1we = $urandom_range(0, 1) == 1;
         c0a = $urandom; c1a = $urandom; c0d = rnd_line(); c1d = rnd_line();
         mrdy = ($urandom_range(0, 9) < 6);
         mack = ($urandom_range(0, 9) < 4);
         mrd = rnd_line();
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set request address width.
REQ-002 Parameter DATA_W, default 128, SHALL set request/response data width (one cache line).
REQ-003 clk  input  1  SHALL be the single clock; all state on rising edge.
REQ-004 rst  input  1  SHALL be asynchronous, active-high reset.
REQ-005 cN_req_valid (N=0 instruction, N=1 data)  input  1  SHALL mean requester N presents a request.
REQ-006 cN_req_ready  output  1  SHALL mean the arbiter accepts requester N's request this cycle.
REQ-007 cN_req_we  input  1  SHALL mean write (1) or read (0).
REQ-008 cN_req_addr  input  ADDR_W  SHALL be the request address.
REQ-009 cN_req_data  input  DATA_W  SHALL be the write data.
REQ-010 cN_resp_ack  output  1  SHALL mean the response for requester N completes this cycle.
REQ-011 cN_resp_data  output  DATA_W  SHALL be read data, valid with cN_resp_ack.
REQ-012 m_req_valid / m_req_we / m_req_addr / m_req_data  output  1/1/ADDR_W/DATA_W  SHALL drive the shared memory bus request.
REQ-013 m_req_ready  input  1  SHALL mean memory accepts the request.
REQ-014 m_resp_ack / m_resp_data  input  1/DATA_W  SHALL mean memory completes with read data.
REQ-015 busy  output  1  SHALL be high whenever state is not IDLE.

Function
REQ-016 FSM states SHALL be IDLE, REQ, RESP; exactly one transaction outstanding on the bus at any time.
REQ-017 In IDLE with any cN_req_valid, the arbiter SHALL select one winner, pulse its cN_req_ready for exactly that cycle, latch we/addr/data and winner ID into registers, and go to REQ.
REQ-018 cN_req_ready SHALL never be asserted outside IDLE and never for the losing requester.
REQ-019 In REQ, m_req_valid SHALL be 1 with latched fields held stable until the cycle m_req_ready=1; then the FSM SHALL go to RESP.
REQ-020 Grant-to-bus latency SHALL be one cycle: m_req_valid rises the cycle after the cN_req_ready pulse.
REQ-021 In RESP, m_resp_ack SHALL be forwarded combinationally to the latched winner's cN_resp_ack with m_resp_data on cN_resp_data; the other requester's ack SHALL stay 0; the FSM SHALL return to IDLE next cycle.
REQ-022 m_resp_ack in IDLE or REQ SHALL be ignored (no ack forwarded, no state change).
REQ-023 Writes SHALL also wait for m_resp_ack; cN_resp_data for writes is don't-care.
REQ-024 cN_resp_data SHALL be 0 when cN_resp_ack is 0.
REQ-025 Back-to-back: after RESP completes, a pending request SHALL be granted in the following IDLE cycle (minimum 3 cycles per transaction plus memory wait).

Reset
REQ-026 On rst: state IDLE, all outputs 0, latched fields 0, winner ID 0, round-robin pointer selecting port 0 on first tie; an in-flight transaction SHALL be abandoned without ack.

Configuration
REQ-027 With ARB_ROUND_ROBIN_EN defined, ties SHALL go to the port not granted most recently (pointer updated on each grant); without it, port 1 (data) SHALL always win ties and no pointer register SHALL exist.

Verification
REQ-028 Single read: c0 valid addr 0x1000 -> c0_req_ready pulse cycle t, m_req_valid t+1 addr 0x1000 we=0; m_req_ready t+1, m_resp_ack t+3 data 0xA5.. -> c0_resp_ack t+3 with 0xA5.., c1_resp_ack 0.
REQ-029 Tie, round-robin build: c0 and c1 continuously valid, memory always ready with 1-cycle ack -> grants alternate 0,1,0,1; fixed build: only c1 granted while c1 valid.
REQ-030 Memory backpressure: m_req_ready low 5 cycles -> m_req_valid/addr/data/we stable all 5 cycles, no cN_req_ready asserted, busy=1.
REQ-031 Spurious m_resp_ack in IDLE and in REQ -> no cN_resp_ack, state unchanged.
REQ-032 rst asserted asynchronously during RESP -> outputs 0 immediately, IDLE after release, no ack ever delivered for abandoned request; next c1 write 0x2000 completes normally.
